// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter for a single-ported memory; MEM_PORT_ARB_RR_EN selects round-robin
module mem_port_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic [1:0]  if_access_size,
  output logic        if_grant,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_access_size,
  input  logic [31:0] d_wdata,
  output logic        d_wbeat,
  output logic        d_grant,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic        mem_busy,
  input  logic [31:0] mem_data_out
);
  typedef enum logic [1:0] {IDLE, BEAT, DRAIN} state_t;
  state_t state, state_nx;
  logic own_f, rw, rv_q, done_q, f_win, any_req, accept, last_beat, arb;
  logic [31:0] base;
  logic [3:0] k, last_k;

  function automatic logic [3:0] last_of(input logic [1:0] s);
    return s == 2'b00 ? 4'd0 : s == 2'b01 ? 4'd3 : s == 2'b10 ? 4'd7 : 4'd15;
  endfunction

  assign any_req = if_req || d_req;
  assign arb = state == IDLE && any_req;

`ifdef MEM_PORT_ARB_RR_EN
  logic last_f;
  assign f_win = if_req && (!d_req || !last_f);
  // last_f starts at 1 so data wins the first contention after reset
  always_ff @(posedge clock)
    if (reset) last_f <= 1'b1;
    else if (arb) last_f <= f_win;
`else
  logic [7:0] starve_cnt;
  assign f_win = if_req && (!d_req || starve_cnt == 8'(MAX_WAIT));
  always_ff @(posedge clock)
    if (reset || !if_req) starve_cnt <= '0;
    else if (state == IDLE) starve_cnt <= f_win ? 8'd0 : starve_cnt + 8'd1;
`endif

  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx    = state;
    if_grant    = 1'b0;
    d_grant     = 1'b0;
    mem_enable  = 1'b0;
    mem_address = '0;
    mem_rw      = 1'b0;
    accept      = 1'b0;
    last_beat   = k == last_k;
    unique case (state)
      IDLE: if (any_req && !reset) begin
        if_grant = f_win;
        d_grant  = !f_win;
        state_nx = BEAT;
      end
      BEAT: begin
        mem_enable  = 1'b1;
        mem_address = base + {26'b0, k, 2'b00};
        mem_rw      = rw;
        accept      = !mem_busy;
        state_nx    = accept && last_beat ? (rw ? DRAIN : IDLE) : BEAT;
      end
      DRAIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock)
    if (reset) begin
      own_f  <= 1'b0;
      rw     <= 1'b0;
      base   <= '0;
      k      <= '0;
      last_k <= '0;
      rv_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rv_q   <= accept && rw;
      done_q <= accept && rw && last_beat;
      if (arb) begin
        own_f  <= f_win;
        rw     <= f_win ? 1'b1 : d_rw;
        base   <= f_win ? if_addr : d_addr;
        last_k <= last_of(f_win ? if_access_size : d_access_size);
        k      <= '0;
      end else if (accept) k <= k + 4'd1;
    end

  assign d_wbeat         = accept && !own_f && !rw;
  assign if_rvalid       = rv_q && own_f;
  assign d_rvalid        = rv_q && !own_f;
  assign if_done         = done_q && own_f;
  assign d_done          = (done_q && !own_f) || (d_wbeat && last_beat);
  assign if_rdata        = if_rvalid ? mem_data_out : '0;
  assign d_rdata         = d_rvalid ? mem_data_out : '0;
  assign mem_data_in     = state == BEAT && !rw ? d_wdata : '0;
  assign mem_access_size = 2'b00;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clock = 1'b0, reset = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_rw = 1'b0, mem_busy = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_data_out = '0;
  logic [1:0]  if_access_size = '0, d_access_size = '0;
  logic        if_grant, if_rvalid, if_done, d_wbeat, d_grant, d_rvalid, d_done, mem_rw, mem_enable;
  logic [31:0] if_rdata, d_rdata, mem_address, mem_data_in;
  logic [1:0]  mem_access_size;
  int checks = 0, errors = 0, nrv;
  logic fw;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_access_size(if_access_size),
    .if_grant(if_grant), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_access_size(d_access_size),
    .d_wdata(d_wdata), .d_wbeat(d_wbeat), .d_grant(d_grant), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
    .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] busy_t [6] = '{0, 1, 1, 0, 0, 0};
    logic [31:0] addr_t [6] = '{32'h80020010, 32'h80020014, 32'h80020014, 32'h80020014, 32'h80020018, 32'h8002001C};
    logic [31:0] wb_t   [6] = '{1, 0, 0, 1, 1, 1};
    logic [31:0] dn_t   [6] = '{0, 0, 0, 0, 0, 1};
    int wi;
    nxt();
    mid();
    chk("rst_enable", mem_enable, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_grants", {if_grant, d_grant}, 0);
    chk("rst_valid", {if_rvalid, d_rvalid, if_done, d_done, d_wbeat}, 0);
    nxt();
    // 1: single-word fetch
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h80020000; if_access_size = 2'b00;
    mid();
    chk("t1_if_grant", if_grant, 1);
    chk("t1_d_grant", d_grant, 0);
    chk("t1_idle_enable", mem_enable, 0);
    nxt();
    mid();
    chk("t1_enable", mem_enable, 1);
    chk("t1_addr", mem_address, 32'h80020000);
    chk("t1_rw", mem_rw, 1);
    chk("t1_grant_pulse", if_grant, 0);
    chk("t1_size", mem_access_size, 0);
    nxt();
    mem_data_out = 32'h1234ABCD;
    mid();
    chk("t1_rvalid", if_rvalid, 1);
    chk("t1_rdata", if_rdata, 32'h1234ABCD);
    chk("t1_done", if_done, 1);
    chk("t1_drain_enable", mem_enable, 0);
    nxt();
    if_req = 1'b0;
    mid();
    chk("t1_post_rvalid", if_rvalid, 0);
    chk("t1_post_done", if_done, 0);
    nxt();
    // 2: 4-word write with two busy cycles on beat 1
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h80020010; d_access_size = 2'b01; wi = 0;
    d_wdata = 32'hD0000000;
    mid();
    chk("t2_d_grant", d_grant, 1);
    chk("t2_if_grant", if_grant, 0);
    nxt();
    for (int i = 0; i < 6; i++) begin
      mem_busy = busy_t[i][0];
      d_wdata = 32'hD0000000 + 32'(wi);
      mid();
      chk("t2_addr", mem_address, addr_t[i]);
      chk("t2_rw", mem_rw, 0);
      chk("t2_wbeat", d_wbeat, wb_t[i]);
      chk("t2_done", d_done, dn_t[i]);
      chk("t2_wdata", mem_data_in, 32'hD0000000 + 32'(wi));
      if (d_wbeat) wi++;
      nxt();
    end
    mem_busy = 1'b0; d_req = 1'b0;
    mid();
    chk("t2_wbeats", 32'(wi), 4);
    chk("t2_idle_enable", mem_enable, 0);
    chk("t2_idle_done", d_done, 0);
    nxt();
    // 3: continuous contention with 1-word reads
    reset = 1'b1;
    nxt();
    nxt();
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h1000; if_access_size = 2'b00;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h2000; d_access_size = 2'b00;
    for (int i = 0; i < 18; i++) begin
`ifdef MEM_PORT_ARB_RR_EN
      fw = (i % 2) == 1;
`else
      fw = (i % 9) == 8;
`endif
      mid();
      chk("t3_if_grant", if_grant, fw);
      chk("t3_d_grant", d_grant, !fw);
      nxt();
      mid();
      chk("t3_addr", mem_address, fw ? 32'h1000 : 32'h2000);
      nxt();
      mem_data_out = 32'hC0000000 + 32'(i);
      mid();
      chk("t3_if_rvalid", {if_rvalid, if_done}, fw ? 2 'b11 : 2'b00);
      chk("t3_d_rvalid", {d_rvalid, d_done}, fw ? 2'b00 : 2'b11);
      chk("t3_rdata", fw ? if_rdata : d_rdata, 32'hC0000000 + 32'(i));
      nxt();
    end
    if_req = 1'b0; d_req = 1'b0;
    nxt();
    // 4: 16-word fetch wrapping past 2^32
    if_req = 1'b1; if_addr = 32'hFFFFFFF8; if_access_size = 2'b11; nrv = 0;
    mid();
    chk("t4_grant", if_grant, 1);
    nxt();
    for (int b = 0; b < 16; b++) begin
      mem_data_out = 32'hA0000000 + 32'(b - 1);
      mid();
      chk("t4_addr", mem_address, 32'hFFFFFFF8 + 32'(4 * b));
      chk("t4_rvalid", if_rvalid, b > 0);
      chk("t4_done", if_done, 0);
      if (b > 0) chk("t4_rdata", if_rdata, 32'hA0000000 + 32'(b - 1));
      if (if_rvalid) nrv++;
      nxt();
    end
    mem_data_out = 32'hA000000F;
    mid();
    if (if_rvalid) nrv++;
    chk("t4_last_rdata", if_rdata, 32'hA000000F);
    chk("t4_last_done", if_done, 1);
    chk("t4_rvalid_count", 32'(nrv), 16);
    nxt();
    if_req = 1'b0;
    mid();
    chk("t4_wrap_check", 32'hFFFFFFF8 + 32'd8, 32'h00000000 + 32'(nrv - 16));
    nxt();
    // 5: reset during beat 3 of an 8-word read
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h100; d_access_size = 2'b10;
    mid();
    chk("t5_grant", d_grant, 1);
    nxt();
    for (int b = 0; b < 3; b++) begin
      mem_data_out = 32'hB0000000 + 32'(b);
      mid();
      chk("t5_addr", mem_address, 32'h100 + 32'(4 * b));
      chk("t5_rvalid", d_rvalid, b > 0);
      nxt();
    end
    reset = 1'b1; d_req = 1'b0;
    mid();
    chk("t5_beat3_addr", mem_address, 32'h10C);
    nxt();
    mid();
    chk("t5_rst_enable", mem_enable, 0);
    chk("t5_rst_addr", mem_address, 0);
    chk("t5_rst_rvalid", {d_rvalid, d_done, if_rvalid, if_done}, 0);
    chk("t5_rst_rdata", d_rdata, 0);
    nxt();
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h200; if_access_size = 2'b00;
    mid();
    chk("t5_if_grant", if_grant, 1);
    chk("t5_d_done", d_done, 0);
    nxt();
    mid();
    chk("t5_if_addr", mem_address, 32'h200);
    nxt();
    mem_data_out = 32'h77;
    mid();
    chk("t5_if_done", {if_rvalid, if_done}, 2'b11);
    chk("t5_if_rdata", if_rdata, 32'h77);
    nxt();
    if_req = 1'b0;
    mid();
    chk("t5_quiet", {if_rvalid, d_done, mem_enable}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
